// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: TX mux selects and frame-sequencer state encoding.
package uart_tx_pkg;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  // Line select for a state; idle and stop both hold the line at mark level.
  function automatic logic [1:0] mux_of(tx_state_e s);
    case (s)
      StStart:  mux_of = MUX_START;
      StData:   mux_of = MUX_DATA;
      StParity: mux_of = MUX_PAR;
      default:  mux_of = MUX_STOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit up-counter with synchronous clear and enable; tc flags the last data bit.
module uart_tx_bit_cnt #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop period.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  tx_state_e state, state_nxt;
  logic      par_en_q;
  logic      tc;
  logic      cnt_clr;
  logic      cnt_en;
  logic      stop_last;
  logic      accept;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stop_cnt <= 1'b0;
    end else if (state == StStop) begin
      stop_cnt <= ~stop_cnt;
    end else begin
      stop_cnt <= 1'b0;
    end
  end

  assign stop_last = stop_cnt;
`else
  assign stop_last = 1'b1;
`endif

  // A new frame may only be accepted from idle or the final stop cycle.
  assign accept   = Data_Valid && ((state == StIdle) || ((state == StStop) && stop_last));
  assign ser_load = accept;
  assign cnt_en   = (state == StData);
  assign cnt_clr  = accept || ((state == StData) && tc);

  always_comb begin
    state_nxt = StIdle;
    case (state)
      StIdle:   state_nxt = Data_Valid ? StStart : StIdle;
      StStart:  state_nxt = StData;
      StData:   state_nxt = tc ? (par_en_q ? StParity : StStop) : StData;
      StParity: state_nxt = StStop;
      StStop: begin
        if (!stop_last)      state_nxt = StStop;
        else if (Data_Valid) state_nxt = StStart;
        else                 state_nxt = StIdle;
      end
      default:  state_nxt = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= StIdle;
      par_en_q <= 1'b0;
      mux_sel  <= MUX_STOP;
      busy     <= 1'b0;
      ser_en   <= 1'b0;
    end else begin
      state   <= state_nxt;
      mux_sel <= mux_of(state_nxt);
      busy    <= (state_nxt != StIdle);
      ser_en  <= (state_nxt == StData);
      if (accept) begin
        par_en_q <= PAR_EN;
      end
    end
  end

  uart_tx_bit_cnt #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_bit_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: per-cycle stimulus and expected outputs queued, then replayed.
module tb_uart_tx_ctrl;

  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NStop = 2;
`else
  localparam int NStop = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       ser_load;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       busy;

  typedef struct packed {
    logic       dv;
    logic       par;
    logic [1:0] mux;
    logic       busy;
    logic       en;
    logic       load;
  } cyc_t;

  cyc_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_ctrl #(
    .DATA_WIDTH (DW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .ser_load   (ser_load),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add(input logic dv, input logic par, input logic [1:0] mux,
                     input logic b, input logic en, input logic load);
    sb_q.push_back(cyc_t'{dv, par, mux, b, en, load});
  endtask

  task automatic gen_req(input logic par);
    add(1'b1, par, 2'b01, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
  endtask

  // dv_mid drives Data_Valid high and flips PAR_EN in every cycle where a request must be ignored.
  task automatic gen_frame(input logic par, input logic dv_mid, input logic chain,
                           input logic next_par);
    add(dv_mid, ~par, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DW; i++) add(dv_mid, ~par, 2'b10, 1'b1, 1'b1, 1'b0);
    if (par) add(dv_mid, ~par, 2'b11, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < NStop; s++) begin
      if (s == NStop - 1) add(chain, next_par, 2'b01, 1'b1, 1'b0, chain);
      else                add(dv_mid, ~par, 2'b01, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic run_sb(input string tag);
    cyc_t c;
    int   k = 0;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      Data_Valid = c.dv;
      PAR_EN     = c.par;
      @(negedge CLK);
      check_eq($sformatf("%s c%0d mux_sel", tag, k), {2'b00, mux_sel}, {2'b00, c.mux});
      check_eq($sformatf("%s c%0d busy", tag, k), {3'b000, busy}, {3'b000, c.busy});
      check_eq($sformatf("%s c%0d ser_en", tag, k), {3'b000, ser_en}, {3'b000, c.en});
      check_eq($sformatf("%s c%0d ser_load", tag, k), {3'b000, ser_load}, {3'b000, c.load});
      @(posedge CLK);
      #1;
      k++;
    end
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("reset mux_sel", {2'b00, mux_sel}, 4'h1);
    check_eq("reset busy", {3'b000, busy}, 4'h0);
    check_eq("reset ser_en", {3'b000, ser_en}, 4'h0);
    check_eq("reset ser_load", {3'b000, ser_load}, 4'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Single frame, no parity.
    gen_req(1'b0);
    gen_frame(1'b0, 1'b0, 1'b0, 1'b0);
    gen_idle(2);
    run_sb("t1");

    // Single frame with parity.
    gen_req(1'b1);
    gen_frame(1'b1, 1'b0, 1'b0, 1'b0);
    gen_idle(1);
    run_sb("t2");

    // Data_Valid held high: back-to-back frames, load in each final stop cycle.
    gen_req(1'b0);
    gen_frame(1'b0, 1'b1, 1'b1, 1'b0);
    gen_frame(1'b0, 1'b1, 1'b1, 1'b0);
    gen_frame(1'b0, 1'b1, 1'b0, 1'b0);
    gen_idle(1);
    run_sb("t3");

    // Mid-frame requests ignored, PAR_EN toggled mid-frame both ways.
    gen_req(1'b1);
    gen_frame(1'b1, 1'b1, 1'b0, 1'b0);
    gen_idle(1);
    gen_req(1'b0);
    gen_frame(1'b0, 1'b1, 1'b0, 1'b1);
    gen_idle(2);
    run_sb("t4");

    // Reset during the 4th data cycle.
    gen_req(1'b0);
    add(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
    run_sb("t5a");
    @(negedge CLK);
    check_eq("t5 pre-reset mux_sel", {2'b00, mux_sel}, 4'h2);
    #1;
    RST = 1'b0;
    #1;
    check_eq("t5 reset mux_sel", {2'b00, mux_sel}, 4'h1);
    check_eq("t5 reset busy", {3'b000, busy}, 4'h0);
    check_eq("t5 reset ser_en", {3'b000, ser_en}, 4'h0);
    check_eq("t5 reset ser_load", {3'b000, ser_load}, 4'h0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    gen_idle(1);
    gen_req(1'b0);
    gen_frame(1'b0, 1'b0, 1'b0, 1'b0);
    gen_idle(1);
    run_sb("t5b");

    // Parity frame; request in a non-final stop cycle ignored, in the final one chained.
    gen_req(1'b1);
    gen_frame(1'b1, 1'b1, 1'b1, 1'b0);
    gen_frame(1'b0, 1'b0, 1'b0, 1'b0);
    gen_idle(1);
    run_sb("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
